camera_config_sccb: RTL and testbench
=====================================

Name: camera_config_sccb

Overview:
- Drives the camera's SCCB (I2C-like) write bus from the camera register-setup ROM.
- Steps the ROM address from 0 to NUM_REGS-1. For each entry it fetches the {register, value} pair and issues one 3-phase SCCB write: ID 0x42, register, value.
- Sits between the setup ROM (upstream) and the camera SIOC/SIOD pins (downstream). It flags `done` so the capture path can start after configuration.

Parameters:
- NUM_REGS, 26: number of ROM entries to write (addresses 0..NUM_REGS-1); legal range 1..64.
- CLK_DIV, 250: clk cycles per SCCB quarter-bit (100 MHz -> 100 kHz SIOC).
- GAP_Q, 8: idle quarters after each STOP (bus-free time).
- AUTO_START, 1: 1 = begin the sequence automatically on reset release; 0 = wait for `start`.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; requests a full configuration run
- rom_addr  out  6  address to the setup ROM
- rom_register  in  8  ROM register field; registered, valid 1 cycle after rom_addr changes
- rom_value  in  8  ROM value field; same timing as rom_register
- sioc  out  1  SCCB clock; idle high
- siod_oe  out  1  1 = pull SIOD low, 0 = release; the top level builds the open-drain pad
- busy  out  1  high while a run is in progress
- done  out  1  high once all NUM_REGS writes have finished; held until the next run or reset

Behaviour:
- Reset (async assert, immediate):
  - sioc=1, siod_oe=0, rom_addr=0, busy=0, done=0, state IDLE.
  - Synchronous deassert is handled by the top-level reset synchronizer.
- Quarter tick:
  - Counter 0..CLK_DIV-1; tick when it wraps.
  - Counter is cleared on entry to START, so all phase boundaries are tick-aligned.
- States: IDLE -> LOAD -> START -> BITS -> STOP -> GAP -> (LOAD | DONE).
- IDLE:
  - Bus idle (sioc=1, siod_oe=0).
  - Leaves on `start`, or on the first cycle after reset if AUTO_START=1.
  - Sets busy=1, done=0, rom_addr=0.
- LOAD: exactly 2 cycles (ROM address register, then ROM output register). At the end it latches the 27-bit shift word {0x42, X, rom_register, X, rom_value, X}, where each X is a don't-care (released) slot.
- START: 4 quarters.
  - q0-q1: sioc=1, siod_oe=0.
  - q2-q3: sioc=1, siod_oe=1 (SDA falls while SCL is high).
- BITS: 27 bits, MSB first, 4 quarters each.
  - q0-q1: sioc=0.
  - q2-q3: sioc=1.
  - siod_oe=~bit is updated only at the q0 boundary.
  - Don't-care slots (bit 9 of each phase) drive siod_oe=0; the slave ACK is not sampled.
- STOP: 4 quarters.
  - q0: sioc=0, siod_oe=1.
  - q1: sioc=1, siod_oe=1.
  - q2-q3: sioc=1, siod_oe=0 (SDA rises while SCL is high).
- GAP: GAP_Q quarters of idle bus. Then:
  - if rom_addr==NUM_REGS-1 -> DONE;
  - else rom_addr+1 -> LOAD.
- DONE: busy=0, done=1, bus idle. `start` re-enters the run exactly as from IDLE.
- Timing: each write takes 2 + (4+108+4+GAP_Q)*CLK_DIV cycles. `done` rises NUM_REGS times that many cycles after the edge that samples `start`.
- `start` while busy=1 is ignored; no queuing.
- Bus transitions: siod_oe changes only while sioc=0, except at the START and STOP edges.
- rom_addr never exceeds NUM_REGS-1; no wrap-around.
- Reset mid-write: the bus returns idle immediately. The slave sees an aborted transfer, which is acceptable. The next run restarts from address 0.

Decomposition:
- Package `camera_sccb_pkg`:
  - SCCB_ID_WRITE = 8'h42
  - quarter counts for START/STOP (4 each) and BITS (27)
  - state enum
- Sub-module `sccb_writer`:
  - Inputs: 8-bit register/value, `go` pulse.
  - Outputs: sioc, siod_oe, `ack_done` pulse at the end of GAP.
  - Owns the quarter-tick counter, shift word and START/BITS/STOP/GAP sequencing.
- The top module keeps IDLE/LOAD/DONE, rom_addr, busy and done.

Test Plan:
1. Reset, AUTO_START=0, no start -> sioc=1, siod_oe=0, rom_addr=0, busy=0, done=0, held 1000 cycles.
2. CLK_DIV=2, GAP_Q=8, NUM_REGS=26, ROM model, SCCB slave model, pulse start -> 26 triples decoded:
   - first (0x42,0x12,0x04), second (0x42,0x11,0x80), last (0x42,0xB0,0x84);
   - done rises exactly 6500 cycles after start is sampled;
   - busy falls on the same edge.
3. Protocol checker during scenario 2:
   - SIOC period 8 clks;
   - siod_oe changes only while sioc=0 except at START/STOP;
   - siod_oe=0 in every don't-care slot;
   - 26 START and 26 STOP conditions.
4. Pulse start at cycle 100 of a run -> no effect, run completes unchanged. Pulse start after done -> done falls next cycle, rom_addr=0, identical 26 writes repeat.
5. AUTO_START=1, assert rst_n low mid-byte of write 10 -> sioc=1 and siod_oe=0 in the same cycle. Release -> sequence restarts at rom_addr=0, completes all 26 writes, done=1.
6. NUM_REGS=1 -> exactly one write (0x42,0x12,0x04), then done with rom_addr still 0.

Source files
------------

// File: rtl/camera_sccb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : camera_sccb_pkg
// Description : Shared constants, state encodings and the shift-word builder
//               for the camera SCCB configuration block.
// Revision    : 1.0 - initial release
// ============================================================================
package camera_sccb_pkg;

  localparam logic [7:0] SCCB_ID_WRITE  = 8'h42;
  localparam int         START_QUARTERS = 4;
  localparam int         STOP_QUARTERS  = 4;
  localparam int         BIT_QUARTERS   = 4;
  localparam int         FRAME_BITS     = 27;

  // Top-level sequencing: the writer owns everything between LOAD and DONE.
  typedef enum logic [1:0] {
    TOP_IDLE  = 2'd0,
    TOP_LOAD  = 2'd1,
    TOP_WRITE = 2'd2,
    TOP_DONE  = 2'd3
  } top_state_e;

  typedef enum logic [2:0] {
    WR_IDLE  = 3'd0,
    WR_START = 3'd1,
    WR_BITS  = 3'd2,
    WR_STOP  = 3'd3,
    WR_GAP   = 3'd4
  } wr_state_e;

  // Three 9-bit phases; the ninth slot of each is released (1 -> siod_oe=0)
  // so the slave may drive its ACK, which is never sampled.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] reg_addr,
                                                        input logic [7:0] value);
    return {SCCB_ID_WRITE, 1'b1, reg_addr, 1'b1, value, 1'b1};
  endfunction

endpackage
`default_nettype wire

// File: rtl/camera_config_sccb_writer.sv
`default_nettype none
// ============================================================================
// Module      : sccb_writer
// Description : Issues one 3-phase SCCB write (ID, register, value) per `go`
//               pulse: START, 27 bits MSB first, STOP, then GAP_Q idle
//               quarters of bus-free time.
// Ports       : clk, rst_n          - clock, async active-low reset
//               go_i                - latch reg_i/value_i and begin a write
//               reg_i, value_i      - register address and data byte
//               sioc_o, siod_oe_o   - SCCB clock, SIOD pull-low enable
//               ack_done_o          - single-cycle pulse on the last GAP edge
// Revision    : 1.0 - initial release
// ============================================================================
module sccb_writer
  import camera_sccb_pkg::*;
#(
  parameter int CLK_DIV = 250,
  parameter int GAP_Q   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go_i,
  input  logic [7:0] reg_i,
  input  logic [7:0] value_i,
  output logic       sioc_o,
  output logic       siod_oe_o,
  output logic       ack_done_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  wr_state_e             state_q;
  logic [DIV_W-1:0]      div_q;
  logic [7:0]            qcnt_q;    // quarter index within the current phase/bit
  logic [4:0]            bit_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic                  sioc_q;
  logic                  siod_oe_q;

  logic w_tick;
  assign w_tick = (div_q == DIV_W'(CLK_DIV - 1));

  // Combinational so the top can advance on the same edge the GAP ends;
  // this keeps each write at exactly 2 + quarters*CLK_DIV cycles.
  assign ack_done_o = (state_q == WR_GAP) && w_tick && (qcnt_q == 8'(GAP_Q - 1));
  assign sioc_o     = sioc_q;
  assign siod_oe_o  = siod_oe_q;

  // Outputs are registered and updated on the edge that enters each new
  // quarter, so every assignment below sets the value for the next quarter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WR_IDLE;
      div_q     <= '0;
      qcnt_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '1;
      sioc_q    <= 1'b1;
      siod_oe_q <= 1'b0;
    end else if (state_q == WR_IDLE) begin
      sioc_q    <= 1'b1;
      siod_oe_q <= 1'b0;
      if (go_i) begin
        state_q <= WR_START;
        div_q   <= '0;
        qcnt_q  <= '0;
        bit_q   <= '0;
        shift_q <= build_frame(reg_i, value_i);
      end
    end else if (!w_tick) begin
      div_q <= div_q + 1'b1;
    end else begin
      div_q <= '0;
      case (state_q)
        WR_START: begin
          if (qcnt_q == 8'(START_QUARTERS - 1)) begin
            state_q   <= WR_BITS;
            qcnt_q    <= '0;
            bit_q     <= '0;
            sioc_q    <= 1'b0;
            siod_oe_q <= ~shift_q[FRAME_BITS-1];
          end else begin
            qcnt_q <= qcnt_q + 8'd1;
            // SDA falls at the half-way point while SCL stays high.
            if (qcnt_q == 8'd1) siod_oe_q <= 1'b1;
          end
        end
        WR_BITS: begin
          if (qcnt_q == 8'(BIT_QUARTERS - 1)) begin
            qcnt_q <= '0;
            sioc_q <= 1'b0;
            if (bit_q == 5'(FRAME_BITS - 1)) begin
              state_q   <= WR_STOP;
              siod_oe_q <= 1'b1;
            end else begin
              bit_q     <= bit_q + 5'd1;
              shift_q   <= {shift_q[FRAME_BITS-2:0], 1'b1};
              siod_oe_q <= ~shift_q[FRAME_BITS-2];
            end
          end else begin
            qcnt_q <= qcnt_q + 8'd1;
            if (qcnt_q == 8'd1) sioc_q <= 1'b1;
          end
        end
        WR_STOP: begin
          if (qcnt_q == 8'(STOP_QUARTERS - 1)) begin
            state_q <= WR_GAP;
            qcnt_q  <= '0;
          end else begin
            qcnt_q <= qcnt_q + 8'd1;
            if (qcnt_q == 8'd0) sioc_q    <= 1'b1;
            if (qcnt_q == 8'd1) siod_oe_q <= 1'b0;  // SDA rises while SCL high
          end
        end
        WR_GAP: begin
          if (qcnt_q == 8'(GAP_Q - 1)) begin
            state_q <= WR_IDLE;
            qcnt_q  <= '0;
          end else begin
            qcnt_q <= qcnt_q + 8'd1;
          end
        end
        default: state_q <= WR_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/camera_config_sccb.sv
`default_nettype none
// ============================================================================
// Module      : camera_config_sccb
// Description : Walks the camera setup ROM (addresses 0..NUM_REGS-1) and
//               issues one SCCB write per entry, then flags `done`.
// Ports       : clk, rst_n                - clock, async active-low reset
//               start                     - pulse requesting a full run
//               rom_addr                  - setup ROM address
//               rom_register, rom_value   - ROM fields, 1-cycle latency
//               sioc, siod_oe             - SCCB clock, SIOD pull-low enable
//               busy, done                - run in progress / run complete
// Revision    : 1.0 - initial release
// ============================================================================
module camera_config_sccb
  import camera_sccb_pkg::*;
#(
  parameter int NUM_REGS   = 26,
  parameter int CLK_DIV    = 250,
  parameter int GAP_Q      = 8,
  parameter int AUTO_START = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [5:0] rom_addr,
  input  logic [7:0] rom_register,
  input  logic [7:0] rom_value,
  output logic       sioc,
  output logic       siod_oe,
  output logic       busy,
  output logic       done
);

  localparam logic [5:0] LAST_ADDR = 6'(NUM_REGS - 1);

  top_state_e state_q;
  logic       load_q;     // second LOAD cycle: ROM output register is valid
  logic       auto_q;     // pending automatic start after reset release
  logic [5:0] rom_addr_q;
  logic       busy_q;
  logic       done_q;

  logic w_go;
  logic w_ack;

  assign w_go     = (state_q == TOP_LOAD) && load_q;
  assign rom_addr = rom_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= TOP_IDLE;
      load_q     <= 1'b0;
      auto_q     <= (AUTO_START != 0);
      rom_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        TOP_IDLE, TOP_DONE: begin
          if (start || auto_q) begin
            state_q    <= TOP_LOAD;
            load_q     <= 1'b0;
            auto_q     <= 1'b0;
            rom_addr_q <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
          end
        end
        TOP_LOAD: begin
          if (load_q) state_q <= TOP_WRITE;
          else        load_q  <= 1'b1;
        end
        TOP_WRITE: begin
          if (w_ack) begin
            if (rom_addr_q == LAST_ADDR) begin
              state_q <= TOP_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              rom_addr_q <= rom_addr_q + 6'd1;
              state_q    <= TOP_LOAD;
              load_q     <= 1'b0;
            end
          end
        end
        default: state_q <= TOP_IDLE;
      endcase
    end
  end

  sccb_writer #(
    .CLK_DIV (CLK_DIV),
    .GAP_Q   (GAP_Q)
  ) u_writer (
    .clk        (clk),
    .rst_n      (rst_n),
    .go_i       (w_go),
    .reg_i      (rom_register),
    .value_i    (rom_value),
    .sioc_o     (sioc),
    .siod_oe_o  (siod_oe),
    .ack_done_o (w_ack)
  );

endmodule
`default_nettype wire

// File: tb/tb_camera_config_sccb.sv
`default_nettype none
// ============================================================================
// Module      : tb_camera_config_sccb
// Description : Self-checking bench for camera_config_sccb. Three instances
//               (manual start, auto start, single register) share one clock,
//               one setup-ROM table and one bus-decoding slave model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_camera_config_sccb;

  localparam int CDIV      = 2;
  localparam int GAPQ      = 8;
  localparam int NREGS     = 26;
  localparam int WRITE_CYC = 2 + (4 + 108 + 4 + GAPQ) * CDIV;   // 250

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Setup ROM table shared by every instance.
  logic [7:0] rom_reg [64];
  logic [7:0] rom_val [64];

  // ---------------- instance A: AUTO_START=0, 26 registers ----------------
  logic       rst_a = 1'b0, start_a = 1'b0;
  logic [5:0] addr_a;
  logic [7:0] reg_a, val_a;
  logic       sioc_a, oe_a, busy_a, done_a;
  camera_config_sccb #(.NUM_REGS(NREGS), .CLK_DIV(CDIV), .GAP_Q(GAPQ), .AUTO_START(0)) dut_a (
    .clk(clk), .rst_n(rst_a), .start(start_a), .rom_addr(addr_a), .rom_register(reg_a),
    .rom_value(val_a), .sioc(sioc_a), .siod_oe(oe_a), .busy(busy_a), .done(done_a));
  always @(posedge clk) begin reg_a <= rom_reg[addr_a]; val_a <= rom_val[addr_a]; end

  // ---------------- instance B: AUTO_START=1, 26 registers ----------------
  logic       rst_b = 1'b0, start_b = 1'b0;
  logic [5:0] addr_b;
  logic [7:0] reg_b, val_b;
  logic       sioc_b, oe_b, busy_b, done_b;
  camera_config_sccb #(.NUM_REGS(NREGS), .CLK_DIV(CDIV), .GAP_Q(GAPQ), .AUTO_START(1)) dut_b (
    .clk(clk), .rst_n(rst_b), .start(start_b), .rom_addr(addr_b), .rom_register(reg_b),
    .rom_value(val_b), .sioc(sioc_b), .siod_oe(oe_b), .busy(busy_b), .done(done_b));
  always @(posedge clk) begin reg_b <= rom_reg[addr_b]; val_b <= rom_val[addr_b]; end

  // ---------------- instance C: AUTO_START=0, 1 register ------------------
  logic       rst_c = 1'b0, start_c = 1'b0;
  logic [5:0] addr_c;
  logic [7:0] reg_c, val_c;
  logic       sioc_c, oe_c, busy_c, done_c;
  camera_config_sccb #(.NUM_REGS(1), .CLK_DIV(CDIV), .GAP_Q(GAPQ), .AUTO_START(0)) dut_c (
    .clk(clk), .rst_n(rst_c), .start(start_c), .rom_addr(addr_c), .rom_register(reg_c),
    .rom_value(val_c), .sioc(sioc_c), .siod_oe(oe_c), .busy(busy_c), .done(done_c));
  always @(posedge clk) begin reg_c <= rom_reg[addr_c]; val_c <= rom_val[addr_c]; end

  // ---------------- SCCB slave / protocol monitor -------------------------
  int   sel = 0;
  logic m_sioc, m_oe;
  always_comb begin
    m_sioc = sioc_a;
    m_oe   = oe_a;
    case (sel)
      1: begin m_sioc = sioc_b; m_oe = oe_b; end
      2: begin m_sioc = sioc_c; m_oe = oe_c; end
      default: ;
    endcase
  end

  logic        mon_en = 1'b0;
  logic        p_sioc, p_oe, in_frame;
  int          mbits, n_start, n_stop, proto_err, period_err, slot_err, frame_err;
  int          cyc = 0, last_rise;
  logic [26:0] word;
  logic [26:0] frames [$];

  task automatic mon_reset();
    p_sioc = 1'b1; p_oe = 1'b0; in_frame = 1'b0; mbits = 0; word = '0;
    n_start = 0; n_stop = 0; proto_err = 0; period_err = 0; slot_err = 0; frame_err = 0;
    last_rise = 0;
    frames.delete();
  endtask

  // SDA is the inverse of siod_oe. START = SDA falls with SCL high, STOP =
  // SDA rises with SCL high; any other SDA change must happen with SCL low.
  always @(negedge clk) begin
    if (mon_en) begin
      if (m_oe != p_oe) begin
        if (m_sioc == 1'b0) begin
        end else if (p_sioc && m_sioc) begin
          if (m_oe) begin
            n_start++; in_frame = 1'b1; mbits = 0;
          end else begin
            n_stop++;
            if (in_frame && mbits == 27) frames.push_back(word);
            else frame_err++;
            in_frame = 1'b0;
          end
        end else begin
          proto_err++;
        end
      end
      if (m_sioc && !p_sioc && in_frame && mbits < 27) begin
        if (mbits > 0 && (cyc - last_rise) != 4 * CDIV) period_err++;
        last_rise = cyc;
        word = {word[25:0], ~m_oe};
        if ((mbits == 8 || mbits == 17 || mbits == 26) && m_oe) slot_err++;
        mbits++;
      end
      p_sioc = m_sioc;
      p_oe   = m_oe;
    end
    cyc++;
  end

  // ---------------- checking helpers --------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: entry i of the ROM becomes the write (0x42, reg, value).
  task automatic check_frames(input string tag, input int nregs);
    chk({tag, "_frame_count"}, frames.size(), nregs);
    chk({tag, "_start_conds"}, n_start, nregs);
    chk({tag, "_stop_conds"}, n_stop, nregs);
    chk({tag, "_sda_change_scl_high"}, proto_err, 0);
    chk({tag, "_sioc_period"}, period_err, 0);
    chk({tag, "_dont_care_slot"}, slot_err, 0);
    chk({tag, "_bad_frame"}, frame_err, 0);
    for (int i = 0; i < nregs && i < frames.size(); i++)
      chk($sformatf("%s_write%0d", tag, i),
          {frames[i][26:19], frames[i][17:10], frames[i][8:1]},
          {8'h42, rom_reg[i], rom_val[i]});
  endtask

  typedef struct {
    int          idx;
    logic [23:0] exp;
    string       name;
  } vec_t;
  vec_t vecs [3];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n, r, bad;
    logic prev_busy;

    vecs[0].idx = 0;         vecs[0].exp = 24'h421204; vecs[0].name = "first_write";
    vecs[1].idx = 1;         vecs[1].exp = 24'h421180; vecs[1].name = "second_write";
    vecs[2].idx = NREGS - 1; vecs[2].exp = 24'h42B084; vecs[2].name = "last_write";

    for (int i = 0; i < 64; i++) begin
      rom_reg[i] = 8'($urandom);
      rom_val[i] = 8'($urandom);
    end
    rom_reg[0] = 8'h12;         rom_val[0] = 8'h04;
    rom_reg[1] = 8'h11;         rom_val[1] = 8'h80;
    rom_reg[NREGS-1] = 8'hB0;   rom_val[NREGS-1] = 8'h84;
    mon_reset();

    // ---- 1: reset state, then idle hold with AUTO_START=0 ----
    #23;
    chk("rst_sioc", sioc_a, 1);
    chk("rst_siod_oe", oe_a, 0);
    chk("rst_rom_addr", addr_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    @(negedge clk);
    rst_a = 1'b1; rst_c = 1'b1;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (sioc_a !== 1'b1 || oe_a !== 1'b0 || addr_a !== 6'd0 || busy_a !== 1'b0 || done_a !== 1'b0)
        bad++;
    end
    chk("idle_hold_1000", bad, 0);

    // ---- 2/3/4a: full run with ignored start pulses ----
    repeat ($urandom_range(3, 20)) @(negedge clk);
    sel = 0; mon_reset(); mon_en = 1'b1;
    r = $urandom_range(300, 6000);
    start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    chk("busy_after_start", busy_a, 1);
    n = 0; prev_busy = 1'b1;
    for (int k = 1; k <= 7000; k++) begin
      start_a = (k == 100 || k == r);
      @(posedge clk); #1;
      if (done_a) begin n = k; break; end
      prev_busy = busy_a;
    end
    start_a = 1'b0;
    chk("done_latency", n, NREGS * WRITE_CYC);
    chk("busy_before_done", prev_busy, 1);
    chk("busy_falls_with_done", busy_a, 0);
    chk("rom_addr_at_done", addr_a, NREGS - 1);
    for (int i = 0; i < 3; i++) begin
      if (vecs[i].idx < frames.size())
        chk(vecs[i].name, {frames[vecs[i].idx][26:19], frames[vecs[i].idx][17:10],
                           frames[vecs[i].idx][8:1]}, vecs[i].exp);
      else
        chk(vecs[i].name, 32'hFFFF_FFFF, vecs[i].exp);
    end
    check_frames("run1", NREGS);

    // ---- 4b: restart after done repeats the identical sequence ----
    repeat (10) @(negedge clk);
    chk("done_held", done_a, 1);
    mon_reset();
    start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    chk("restart_done_low", done_a, 0);
    chk("restart_rom_addr", addr_a, 0);
    chk("restart_busy", busy_a, 1);
    n = 0;
    for (int k = 1; k <= 7000; k++) begin
      @(posedge clk); #1;
      if (done_a) begin n = k; break; end
    end
    chk("rerun_done_latency", n, NREGS * WRITE_CYC);
    check_frames("run2", NREGS);
    mon_en = 1'b0;

    // ---- 5: AUTO_START, reset mid-byte of write 10 ----
    @(negedge clk);
    sel = 1; mon_reset(); mon_en = 1'b1;
    rst_b = 1'b1;
    n = 0;
    for (int k = 1; k <= 5000; k++) begin
      @(negedge clk);
      if (frames.size() == 9 && mbits >= 12 && m_sioc == 1'b0) begin n = k; break; end
    end
    chk("reached_write10", (n != 0), 1);
    chk("addr_write10", addr_b, 9);
    mon_en = 1'b0;
    #1 rst_b = 1'b0;
    #1;
    chk("abort_sioc", sioc_b, 1);
    chk("abort_siod_oe", oe_b, 0);
    chk("abort_rom_addr", addr_b, 0);
    chk("abort_busy", busy_b, 0);
    repeat (3) @(negedge clk);
    mon_reset(); mon_en = 1'b1;
    rst_b = 1'b1;
    n = 0;
    for (int k = 1; k <= 7000; k++) begin
      @(posedge clk); #1;
      if (done_b) begin n = k; break; end
    end
    chk("auto_done_latency", n, 1 + NREGS * WRITE_CYC);
    chk("auto_done", done_b, 1);
    check_frames("auto", NREGS);
    mon_en = 1'b0;

    // ---- 6: NUM_REGS=1 ----
    @(negedge clk);
    sel = 2; mon_reset(); mon_en = 1'b1;
    start_c = 1'b1;
    @(posedge clk); #1 start_c = 1'b0;
    n = 0;
    for (int k = 1; k <= 600; k++) begin
      @(posedge clk); #1;
      if (done_c) begin n = k; break; end
    end
    chk("single_done_latency", n, WRITE_CYC);
    chk("single_rom_addr", addr_c, 0);
    chk("single_busy", busy_c, 0);
    check_frames("single", 1);
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
